// File: rtl/mip_pkg.sv
// Shared definitions for the morphological image pipeline.
// Holds the filter mode and FSM state encodings, the mode decode used when
// a frame starts, and the border neutral value used by the min/max tree.
package mip_pkg;

    // Filter operation applied to a whole frame
    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_DIL  = 2'd1,
        MODE_ERO  = 2'd2
    } mode_t;

    // Frame sequencing states of the filter
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Requests from mip_control: exactly one enable selects that operation,
    // none or both selects pass-through
    function automatic mode_t decode_mode(input logic dil, input logic ero);
        if (dil && !ero) begin
            return MODE_DIL;
        end else if (!dil && ero) begin
            return MODE_ERO;
        end
        return MODE_PASS;
    endfunction

    // Border neighbours must never win the compare: all-ones for erosion
    // (min), zero otherwise. Replicate this bit across the pixel width.
    function automatic logic neutral_bit(input mode_t m);
        return (m == MODE_ERO);
    endfunction

endpackage

// File: rtl/mip_line_buffer.sv
// One image row of delay for the 3x3 window.
// Circular buffer: dout is the word written DEPTH advances ago and is read
// before the new word overwrites it in the same cycle.
// Ports:
//   clk   pixel clock
//   rst   synchronous active-high reset (pointer only)
//   en    advance one position
//   din   word entering the row delay
//   dout  word that entered DEPTH advances earlier
module mip_line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    import mip_pkg::*;

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] ptr;

    assign dout = mem[ptr];

    // Contents are never cleared; the top-level border mask hides stale data
    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/mip_morph_filter.sv
// 3x3 grey-level morphological filter between the ROM reader and RAM writer.
// Dilation outputs the window maximum, erosion the window minimum, and
// pass-through the centre pixel. The mode is latched at the first pixel of
// a frame. After the last input pixel the pipeline flushes IMG_W+1 internal
// positions so that every pixel of the frame produces exactly one output.
// Ports:
//   clk, rst                  pixel clock, synchronous active-high reset
//   dilation_en, erosion_en   mode request from mip_control
//   pix_in, pix_in_valid      raster input stream, no backpressure
//   pix_out, pix_out_valid    raster output stream
//   pix_out_sof               marks output pixel (0,0)
//   busy                      frame in progress (RUN/FLUSH/DONE)
//   overrun                   input dropped during FLUSH/DONE (1-cycle pulse)
//   dilation_done             end-of-frame pulse for DIL or PASS frames
//   erosion_done              end-of-frame pulse for ERO or PASS frames
module mip_morph_filter #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dilation_en,
    input  logic             erosion_en,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_in_valid,
    output logic [PIX_W-1:0] pix_out,
    output logic             pix_out_valid,
    output logic             pix_out_sof,
    output logic             busy,
    output logic             overrun,
    output logic             dilation_done,
    output logic             erosion_done
);
    import mip_pkg::*;

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H + 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    state_t state, state_nx;
    mode_t  mode;

    // q_*: position of the next advance; c_*: centre of the next output
    logic [ROW_W-1:0] q_row, c_row;
    logic [COL_W-1:0] q_col, c_col;

    logic accept, adv, out_en, q_last, c_last;
    logic [PIX_W-1:0] pix_d, lb1_out, lb2_out;

    // Window columns: left (oldest), centre, and the arriving column
    logic [PIX_W-1:0] win_l [3];
    logic [PIX_W-1:0] win_c [3];
    logic [PIX_W-1:0] col_new [3];
    logic [PIX_W-1:0] tap [3][3];
    logic [2:0] row_ok, col_ok;
    logic [PIX_W-1:0] nv, v, win_max, win_min, result;

    assign accept = pix_in_valid && (state == ST_IDLE || state == ST_RUN);
    assign adv    = accept || (state == ST_FLUSH);
    assign q_last = (q_row == ROW_LAST) && (q_col == COL_LAST);
    assign c_last = (c_row == ROW_LAST) && (c_col == COL_LAST);

    // The first window completes at position IMG_W+1; every flush position
    // completes a window
    assign out_en = adv && ((state == ST_FLUSH) ||
                            (q_row > ROW_W'(1)) ||
                            (q_row == ROW_W'(1) && q_col != '0));

    // Flush positions lie below the image and are always masked
    assign pix_d = (state == ST_FLUSH) ? '0 : pix_in;

    mip_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk  (clk),
        .rst  (rst),
        .en   (adv),
        .din  (pix_d),
        .dout (lb1_out)
    );

    mip_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb2 (
        .clk  (clk),
        .rst  (rst),
        .en   (adv),
        .din  (lb1_out),
        .dout (lb2_out)
    );

    assign col_new[0] = lb2_out;
    assign col_new[1] = lb1_out;
    assign col_new[2] = pix_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Frame sequencing; FLUSH ends once the last centre has been produced
    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (pix_in_valid) state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (accept && q_last) state_nx = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (c_last) state_nx = ST_DONE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Position counters and mode latch; counters are rearmed in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            mode  <= MODE_PASS;
            q_row <= '0;
            q_col <= '0;
            c_row <= '0;
            c_col <= '0;
        end else if (state == ST_DONE) begin
            q_row <= '0;
            q_col <= '0;
            c_row <= '0;
            c_col <= '0;
        end else begin
            if (state == ST_IDLE && pix_in_valid) begin
                mode <= decode_mode(dilation_en, erosion_en);
            end
            if (accept) begin
                if (q_col == COL_LAST) begin
                    q_col <= '0;
                    q_row <= q_row + ROW_W'(1);
                end else begin
                    q_col <= q_col + COL_W'(1);
                end
            end
            if (out_en) begin
                if (c_col == COL_LAST) begin
                    c_col <= '0;
                    c_row <= c_row + ROW_W'(1);
                end else begin
                    c_col <= c_col + COL_W'(1);
                end
            end
        end
    end

    // Window shift on every advance
    always_ff @(posedge clk) begin
        if (adv) begin
            for (int i = 0; i < 3; i++) begin
                win_l[i] <= win_c[i];
                win_c[i] <= col_new[i];
            end
        end
    end

    // The result is formed from the arriving column so the output lands one
    // cycle after the completing position
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            tap[i][0] = win_l[i];
            tap[i][1] = win_c[i];
            tap[i][2] = col_new[i];
        end
    end

    // Border mask from the centre coordinates; separate left/right masks
    // stop column 0 from seeing the previous row's last column
    always_comb begin
        row_ok = {c_row != ROW_LAST, 1'b1, c_row != '0};
        col_ok = {c_col != COL_LAST, 1'b1, c_col != '0};
    end

    always_comb begin
        nv      = {PIX_W{neutral_bit(mode)}};
        v       = '0;
        win_max = '0;
        win_min = '1;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                v = (row_ok[i] && col_ok[j]) ? tap[i][j] : nv;
                if (v > win_max) win_max = v;
                if (v < win_min) win_min = v;
            end
        end
        case (mode)
            MODE_DIL: result = win_max;
            MODE_ERO: result = win_min;
            default:  result = tap[1][1];
        endcase
    end

    // Registered outputs; done pulses follow the DONE cycle, which carries
    // the last output pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_out       <= '0;
            pix_out_valid <= 1'b0;
            pix_out_sof   <= 1'b0;
            overrun       <= 1'b0;
            dilation_done <= 1'b0;
            erosion_done  <= 1'b0;
        end else begin
            pix_out_valid <= out_en;
            pix_out_sof   <= out_en && (c_row == '0) && (c_col == '0);
            if (out_en) begin
                pix_out <= result;
            end
            overrun       <= pix_in_valid && (state == ST_FLUSH || state == ST_DONE);
            dilation_done <= (state == ST_DONE) && (mode != MODE_ERO);
            erosion_done  <= (state == ST_DONE) && (mode != MODE_DIL);
        end
    end

endmodule

// File: tb/tb_mip_morph_filter.sv
module tb_mip_morph_filter;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    typedef struct packed {
        logic [7:0] pix;
        logic       sof;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       dilation_en;
    logic       erosion_en;
    logic [7:0] pix_in;
    logic       pix_in_valid;
    logic [7:0] pix_out;
    logic       pix_out_valid;
    logic       pix_out_sof;
    logic       busy;
    logic       overrun;
    logic       dilation_done;
    logic       erosion_done;

    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;
    bit   allow_done = 1'b0;
    logic [7:0] img [N];
    exp_t exp_q [$];
    exp_t mon_e;

    mip_morph_filter #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .dilation_en   (dilation_en),
        .erosion_en    (erosion_en),
        .pix_in        (pix_in),
        .pix_in_valid  (pix_in_valid),
        .pix_out       (pix_out),
        .pix_out_valid (pix_out_valid),
        .pix_out_sof   (pix_out_sof),
        .busy          (busy),
        .overrun       (overrun),
        .dilation_done (dilation_done),
        .erosion_done  (erosion_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference 3x3 operation straight from the image; m: 0 pass, 1 dil, 2 ero
    function automatic logic [7:0] model(input int m, input int r, input int c);
        int mx = 0;
        int mn = 255;
        if (m == 0) return img[r*W + c];
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                int rr = r + dr;
                int cc = c + dc;
                if (rr >= 0 && rr < H && cc >= 0 && cc < W) begin
                    int v = int'(img[rr*W + cc]);
                    if (v > mx) mx = v;
                    if (v < mn) mn = v;
                end
            end
        end
        return (m == 1) ? 8'(mx) : 8'(mn);
    endfunction

    // Scoreboard consumer: every output must match the head of the queue
    always @(negedge clk) begin
        if (mon_en) begin
            if (!allow_done) checkOutput("done_stray", {30'b0, dilation_done, erosion_done}, 32'd0);
            if (pix_out_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("out_stray", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("pix", {24'b0, pix_out}, {24'b0, mon_e.pix});
                    checkOutput("sof", {31'b0, pix_out_sof}, {31'b0, mon_e.sof});
                end
            end
        end
    end

    // Push the whole frame's expected outputs, then drive it with `gap`
    // idle cycles before each pixel; optionally flip the enables mid-frame
    task automatic applyStimulus(input int m, input int gap, input bit toggle);
        for (int p = 0; p < N; p++) begin
            exp_q.push_back('{pix: model(m, p / W, p % W), sof: (p == 0)});
        end
        for (int p = 0; p < N; p++) begin
            repeat (gap) begin
                pix_in_valid = 1'b0;
                @(negedge clk);
            end
            pix_in_valid = 1'b1;
            pix_in       = img[p];
            if (toggle && p == 5) begin
                dilation_en = 1'b0;
                erosion_en  = 1'b1;
            end
            if (p == 2) checkOutput("busy_run", {31'b0, busy}, 32'd1);
            @(negedge clk);
        end
        pix_in_valid = 1'b0;
    endtask

    task automatic waitFrameEnd(input logic exp_dil, input logic exp_ero);
        bit drained = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) begin
                drained = 1'b1;
                break;
            end
        end
        checkOutput("frame_drain", {31'b0, drained}, 32'd1);
        allow_done = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("dil_done", {31'b0, dilation_done}, {31'b0, exp_dil});
        checkOutput("ero_done", {31'b0, erosion_done}, {31'b0, exp_ero});
        checkOutput("busy_end", {31'b0, busy}, 32'd0);
        allow_done = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        dilation_en  = 1'b0;
        erosion_en   = 1'b0;
        pix_in       = 8'd0;
        pix_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_valid",   {31'b0, pix_out_valid}, 32'd0);
        checkOutput("rst_pix",     {24'b0, pix_out}, 32'd0);
        checkOutput("rst_sof",     {31'b0, pix_out_sof}, 32'd0);
        checkOutput("rst_busy",    {31'b0, busy}, 32'd0);
        checkOutput("rst_overrun", {31'b0, overrun}, 32'd0);
        checkOutput("rst_done",    {30'b0, dilation_done, erosion_done}, 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        $display("[TB] dilation impulse");
        for (int p = 0; p < N; p++) img[p] = 8'd0;
        img[1*W + 1] = 8'd255;
        dilation_en = 1'b1; erosion_en = 1'b0;
        applyStimulus(1, 0, 1'b0);
        waitFrameEnd(1'b1, 1'b0);

        $display("[TB] erosion hole");
        for (int p = 0; p < N; p++) img[p] = 8'd255;
        img[1*W + 2] = 8'd0;
        dilation_en = 1'b0; erosion_en = 1'b1;
        applyStimulus(2, 0, 1'b0);
        waitFrameEnd(1'b0, 1'b1);

        $display("[TB] pass-through ramp");
        for (int p = 0; p < N; p++) img[p] = 8'(p * 17 + 3);
        dilation_en = 1'b1; erosion_en = 1'b1;
        applyStimulus(0, 0, 1'b0);
        waitFrameEnd(1'b1, 1'b1);

        $display("[TB] dilation ramp with gaps");
        for (int p = 0; p < N; p++) img[p] = 8'(p * 20);
        dilation_en = 1'b1; erosion_en = 1'b0;
        applyStimulus(1, 2, 1'b0);
        waitFrameEnd(1'b1, 1'b0);

        $display("[TB] enable toggle mid-frame");
        for (int p = 0; p < N; p++) img[p] = 8'($urandom_range(0, 255));
        dilation_en = 1'b1; erosion_en = 1'b0;
        applyStimulus(1, 0, 1'b1);
        waitFrameEnd(1'b1, 1'b0);

        $display("[TB] reset mid-frame");
        for (int p = 0; p < N; p++) img[p] = 8'($urandom_range(0, 255));
        dilation_en = 1'b0; erosion_en = 1'b1;
        exp_q.push_back('{pix: model(2, 0, 0), sof: 1'b1});
        for (int p = 0; p < 6; p++) begin
            pix_in_valid = 1'b1;
            pix_in       = img[p];
            @(negedge clk);
        end
        pix_in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("abort_drain", exp_q.size(), 32'd0);
        checkOutput("abort_valid", {31'b0, pix_out_valid}, 32'd0);
        checkOutput("abort_busy",  {31'b0, busy}, 32'd0);
        checkOutput("abort_pix",   {24'b0, pix_out}, 32'd0);
        repeat (8) @(negedge clk);
        applyStimulus(2, 0, 1'b0);
        waitFrameEnd(1'b0, 1'b1);

        $display("[TB] overrun in flush");
        for (int p = 0; p < N; p++) img[p] = 8'(255 - p * 11);
        dilation_en = 1'b1; erosion_en = 1'b0;
        applyStimulus(1, 0, 1'b0);
        pix_in_valid = 1'b1;
        pix_in       = 8'hAA;
        @(negedge clk);
        pix_in_valid = 1'b0;
        checkOutput("overrun_hi", {31'b0, overrun}, 32'd1);
        @(negedge clk);
        checkOutput("overrun_lo", {31'b0, overrun}, 32'd0);
        waitFrameEnd(1'b1, 1'b0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
